uart_mmio_regs: RTL and testbench

- CPU-facing register front end for the UART transmit/receive pair.
- Decodes a simple single-cycle bus into DATA/STATUS/CTRL registers.
- Buffers outgoing bytes in a TX FIFO and issues one-cycle send pulses to the transmitter.
- Captures bytes from the receiver into an RX FIFO with clear-on-read data and sticky error flags.

---
 rtl/uart_mmio_regs.sv | 162 ++++++++++++++++
 tb/tb_uart_mmio_regs.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_regs.sv
// CPU register front end for a UART TX/RX pair: DATA/STATUS/CTRL decode, TX/RX FIFOs, send-pulse launcher.
// Optional interrupt logic and CTRL register are built only when UART_MMIO_IRQ_EN is defined.
module uart_mmio_regs #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL_CNT = (RAW+1)'(RX_DEPTH);

    typedef enum logic {TX_IDLE, TX_HOLD} tx_state_e;

    tx_state_e    tx_state_q, tx_state_d;
    logic [7:0]   tx_mem_q [TX_DEPTH];
    logic [7:0]   rx_mem_q [RX_DEPTH];
    logic [TAW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [RAW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [TAW:0] tx_cnt_q, tx_cnt_d;
    logic [RAW:0] rx_cnt_q, rx_cnt_d;
    logic         rx_ovr_q, rx_ovr_d, tx_drop_q, tx_drop_d;
    logic         resp_valid_q, resp_valid_d;
    logic [31:0]  resp_rdata_q, resp_rdata_d;

    logic rd_req, wr_req, addr_data, addr_status, addr_ctrl;
    logic tx_full, tx_push, tx_pop, tx_idle, rx_full, rx_push, rx_pop, rx_nonempty;
    logic [31:0] status_w, ctrl_rd;
    logic unused_wdata;

    assign rd_req      = req_valid & ~req_write;
    assign wr_req      = req_valid & req_write;
    assign addr_data   = (req_addr == 4'h0);
    assign addr_status = (req_addr == 4'h4);
    assign addr_ctrl   = (req_addr == 4'h8);

    assign tx_full     = (tx_cnt_q == TX_FULL_CNT);
    assign rx_full     = (rx_cnt_q == RX_FULL_CNT);
    assign rx_nonempty = (rx_cnt_q != '0);
    assign tx_idle     = (tx_cnt_q == '0) & ~tx_busy & (tx_state_q != TX_HOLD);

    // Launch decision is combinational on registered FIFO state so a write into
    // an empty FIFO reaches tx_send in the very next cycle.
    assign tx_send = (tx_state_q == TX_IDLE) & (tx_cnt_q != '0) & ~tx_busy;
    assign tx_data = tx_send ? tx_mem_q[tx_rd_q] : 8'h00;
    assign tx_pop  = tx_send;
    assign tx_push = wr_req & addr_data & ~tx_full;

    // A same-cycle pop frees a slot for an incoming byte on a full RX FIFO.
    assign rx_pop  = rd_req & addr_data & rx_nonempty;
    assign rx_push = rx_valid & (~rx_full | rx_pop);

    assign status_w = {12'b0, 4'(tx_cnt_q), 4'b0, 4'(rx_cnt_q), 3'b0,
                       tx_drop_q, rx_ovr_q, tx_idle, tx_full, rx_nonempty};

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_wr_d      = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
        tx_rd_d      = tx_pop  ? tx_rd_q + 1'b1 : tx_rd_q;
        rx_wr_d      = rx_push ? rx_wr_q + 1'b1 : rx_wr_q;
        rx_rd_d      = rx_pop  ? rx_rd_q + 1'b1 : rx_rd_q;
        tx_cnt_d     = tx_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        resp_valid_d = rd_req;
        resp_rdata_d = 32'h0;
        case (tx_state_q)
            TX_IDLE: if (tx_send) tx_state_d = TX_HOLD;
            default: tx_state_d = TX_IDLE;
        endcase
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
            default: rx_cnt_d = rx_cnt_q;
        endcase
        // Clear-on-read loses to an error arriving in the same cycle.
        rx_ovr_d  = (rx_ovr_q  & ~(rd_req & addr_status)) | (rx_valid & rx_full & ~rx_pop);
        tx_drop_d = (tx_drop_q & ~(rd_req & addr_status)) | (wr_req & addr_data & tx_full);
        if (rd_req) begin
            if (addr_data && rx_nonempty) resp_rdata_d = {23'b0, 1'b1, rx_mem_q[rx_rd_q]};
            else if (addr_status)         resp_rdata_d = status_w;
            else if (addr_ctrl)           resp_rdata_d = ctrl_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= req_wdata[7:0];
        if (rx_push) rx_mem_q[rx_wr_q] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            tx_cnt_q     <= '0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            rx_cnt_q     <= '0;
            rx_ovr_q     <= 1'b0;
            tx_drop_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_ovr_q     <= rx_ovr_d;
            tx_drop_q    <= tx_drop_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

`ifdef UART_MMIO_IRQ_EN
    logic [1:0] ctrl_q;
    logic       irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= 2'b00;
            irq_q  <= 1'b0;
        end else begin
            if (wr_req && addr_ctrl) ctrl_q <= req_wdata[1:0];
            irq_q <= (ctrl_q[0] & rx_nonempty) | (ctrl_q[1] & tx_idle) | rx_ovr_q | tx_drop_q;
        end
    end

    assign ctrl_rd = {30'b0, ctrl_q};
    assign irq     = irq_q;
`else
    assign ctrl_rd = 32'h0;
    assign irq     = 1'b0;
`endif

    assign unused_wdata = ^req_wdata[31:8];
endmodule

// File: tb/tb_uart_mmio_regs.sv
// Directed bench for uart_mmio_regs: register decode, TX launch timing, FIFO boundaries, sticky flags.
// Define UART_MMIO_IRQ_EN for both files to exercise the interrupt path.
module tb_uart_mmio_regs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [3:0]  req_addr = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        irq;

    int tests_run = 0;
    int tests_failed = 0;
    int b2b_err = 0;
    logic prev_send = 1'b0;
    logic [7:0] sent_q[$];

    uart_mmio_regs #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .tx_send(tx_send), .tx_data(tx_data),
        .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_data(rx_data), .irq(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_send) sent_q.push_back(tx_data);
        if (tx_send && prev_send) b2b_err++;
        prev_send = tx_send;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
        tick();
        req_valid = 1'b0; req_write = 1'b0;
        $display("[TB] write addr=0x%0h data=0x%08h", addr, data);
    endtask

    task automatic do_read(input logic [3:0] addr, output logic vld, output logic [31:0] data);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
        tick();
        req_valid = 1'b0;
        vld = resp_valid; data = resp_rdata;
        $display("[TB] read  addr=0x%0h valid=%0b data=0x%08h", addr, vld, data);
    endtask

    task automatic test_reset();
        logic v; logic [31:0] d;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        tests_run++;
        if ({resp_valid, resp_rdata, tx_send, tx_data, irq} !== 42'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got rv=%0b rd=0x%08h send=%0b data=0x%02h irq=%0b want all 0",
                     resp_valid, resp_rdata, tx_send, tx_data, irq);
        end
        do_read(4'h4, v, d);
        tests_run++;
        if (v !== 1'b1 || d !== 32'h0000_0004) begin
            tests_failed++;
            $display("FAIL reset_status got v=%0b d=0x%08h want v=1 d=0x00000004", v, d);
        end
        tick();
        tests_run++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL idle_resp got v=%0b d=0x%08h want 0/0", resp_valid, resp_rdata);
        end
    endtask

    task automatic test_tx_launch();
        int early;
        do_write(4'h0, 32'h41);
        tests_run++;
        if (tx_send !== 1'b1 || tx_data !== 8'h41) begin
            tests_failed++;
            $display("FAIL first_launch got send=%0b data=0x%02h want 1/0x41", tx_send, tx_data);
        end
        tick();
        tests_run++;
        if (tx_send !== 1'b0) begin
            tests_failed++;
            $display("FAIL pulse_width got send=%0b want 0", tx_send);
        end
        tx_busy = 1'b1;
        do_write(4'h0, 32'h42);
        early = 0;
        for (int i = 0; i < 9; i++) begin
            if (tx_send !== 1'b0) early++;
            tick();
        end
        tests_run++;
        if (early != 0) begin
            tests_failed++;
            $display("FAIL busy_block got %0d pulses while busy want 0", early);
        end
        tx_busy = 1'b0;
        #1;
        tests_run++;
        if (tx_send !== 1'b1 || tx_data !== 8'h42) begin
            tests_failed++;
            $display("FAIL second_launch got send=%0b data=0x%02h want 1/0x42", tx_send, tx_data);
        end
        tick(); tx_busy = 1'b1; tick(); tick(); tx_busy = 1'b0; tick();
        $display("[TB] tx launch sequence done, %0d bytes sent", sent_q.size());
    endtask

    task automatic test_tx_full();
        logic v; logic [31:0] d;
        int t;
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) do_write(4'h0, 32'hA0 + 32'(i));
        do_read(4'h4, v, d);
        tests_run++;
        if (d !== 32'h0004_0012) begin
            tests_failed++;
            $display("FAIL tx_full_status got 0x%08h want 0x00040012", d);
        end
        do_read(4'h4, v, d);
        tests_run++;
        if (d !== 32'h0004_0002) begin
            tests_failed++;
            $display("FAIL tx_drop_clear got 0x%08h want 0x00040002", d);
        end
        sent_q.delete();
        tx_busy = 1'b0;
        t = 0;
        while (sent_q.size() < 4 && t < 40) begin tick(); t++; end
        tests_run++;
        if (sent_q.size() != 4) begin
            tests_failed++;
            $display("FAIL tx_drain got %0d bytes want 4", sent_q.size());
        end else if (sent_q[0] !== 8'hA0 || sent_q[1] !== 8'hA1 || sent_q[2] !== 8'hA2 || sent_q[3] !== 8'hA3) begin
            tests_failed++;
            $display("FAIL tx_order got %02h %02h %02h %02h want a0 a1 a2 a3",
                     sent_q[0], sent_q[1], sent_q[2], sent_q[3]);
        end
        tick(); tick();
        do_read(4'h4, v, d);
        tests_run++;
        if (d !== 32'h0000_0004) begin
            tests_failed++;
            $display("FAIL tx_drained_status got 0x%08h want 0x00000004", d);
        end
    endtask

    task automatic test_rx_overrun();
        logic v; logic [31:0] d;
        logic [31:0] exp;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_data = 8'h10 + 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        do_read(4'h4, v, d);
        tests_run++;
        if (d !== 32'h0000_040D) begin
            tests_failed++;
            $display("FAIL rx_ovr_status got 0x%08h want 0x0000040d", d);
        end
        for (int i = 0; i < 5; i++) begin
            exp = (i < 4) ? (32'h110 + 32'(i)) : 32'h0;
            do_read(4'h0, v, d);
            tests_run++;
            if (v !== 1'b1 || d !== exp) begin
                tests_failed++;
                $display("FAIL rx_read%0d got v=%0b d=0x%08h want 1/0x%08h", i, v, d, exp);
            end
        end
    endtask

    task automatic test_rx_simultaneous();
        logic v; logic [31:0] d;
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = 8'h20 + 8'(i);
            tick();
        end
        rx_valid = 1'b1; rx_data = 8'h55;
        do_read(4'h0, v, d);
        rx_valid = 1'b0;
        tests_run++;
        if (d !== 32'h0000_0120) begin
            tests_failed++;
            $display("FAIL full_pop_push got 0x%08h want 0x00000120", d);
        end
        do_read(4'h4, v, d);
        tests_run++;
        if (d !== 32'h0000_0405) begin
            tests_failed++;
            $display("FAIL full_pop_status got 0x%08h want 0x00000405", d);
        end
        rx_valid = 1'b1; rx_data = 8'h66;
        do_read(4'h4, v, d);
        rx_valid = 1'b0;
        do_read(4'h4, v, d);
        tests_run++;
        if (d !== 32'h0000_040D) begin
            tests_failed++;
            $display("FAIL ovr_vs_clear got 0x%08h want 0x0000040d", d);
        end
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: exp = 32'h121;
                1: exp = 32'h122;
                2: exp = 32'h123;
                3: exp = 32'h155;
                default: exp = 32'h0;
            endcase
            do_read(4'h0, v, d);
            tests_run++;
            if (d !== exp) begin
                tests_failed++;
                $display("FAIL rx_order%0d got 0x%08h want 0x%08h", i, d, exp);
            end
        end
    endtask

    task automatic test_unmapped();
        logic v; logic [31:0] d;
        do_read(4'hC, v, d);
        tests_run++;
        if (v !== 1'b1 || d !== 32'h0) begin
            tests_failed++;
            $display("FAIL unmapped_read got v=%0b d=0x%08h want 1/0", v, d);
        end
        tx_busy = 1'b1;
        do_write(4'h2, 32'hFF);
        do_read(4'h4, v, d);
        tx_busy = 1'b0;
        tests_run++;
        if (d !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL unmapped_write got status 0x%08h want 0x00000000", d);
        end
    endtask

    task automatic test_reset_mid();
        logic v; logic [31:0] d;
        tx_busy = 1'b1;
        do_write(4'h0, 32'h01);
        do_write(4'h0, 32'h02);
        rx_valid = 1'b1; rx_data = 8'h99; tick(); rx_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        tx_busy = 1'b0;
        #1;
        tests_run++;
        if (tx_send !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_send got %0b want 0", tx_send);
        end
        do_read(4'h4, v, d);
        tests_run++;
        if (d !== 32'h0000_0004) begin
            tests_failed++;
            $display("FAIL reset_mid_status got 0x%08h want 0x00000004", d);
        end
    endtask

    task automatic test_ctrl_irq();
        logic v; logic [31:0] d;
`ifdef UART_MMIO_IRQ_EN
        do_write(4'h8, 32'hFFFF_FFFD);
        do_read(4'h8, v, d);
        tests_run++;
        if (d !== 32'h1) begin
            tests_failed++;
            $display("FAIL ctrl_rw got 0x%08h want 0x00000001", d);
        end
        rx_valid = 1'b1; rx_data = 8'h77; tick(); rx_valid = 1'b0;
        tick();
        tests_run++;
        if (irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_rise got %0b want 1", irq);
        end
        do_read(4'h0, v, d);
        tick();
        tests_run++;
        if (irq !== 1'b0 || d !== 32'h177) begin
            tests_failed++;
            $display("FAIL irq_fall got irq=%0b d=0x%08h want 0/0x00000177", irq, d);
        end
        do_write(4'h8, 32'h0);
`else
        do_write(4'h8, 32'h3);
        do_read(4'h8, v, d);
        tests_run++;
        if (d !== 32'h0) begin
            tests_failed++;
            $display("FAIL ctrl_absent got 0x%08h want 0", d);
        end
        rx_valid = 1'b1; rx_data = 8'h77; tick(); rx_valid = 1'b0;
        tick();
        tests_run++;
        if (irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_tied got %0b want 0", irq);
        end
        do_read(4'h0, v, d);
`endif
    endtask

    task automatic test_back_to_back();
        tests_run++;
        if (b2b_err != 0) begin
            tests_failed++;
            $display("FAIL back_to_back got %0d adjacent pulses want 0", b2b_err);
        end
    endtask

    initial begin
        test_reset();
        test_tx_launch();
        test_tx_full();
        test_rx_overrun();
        test_rx_simultaneous();
        test_unmapped();
        test_reset_mid();
        test_ctrl_irq();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
